// File: rtl/memory1_if.sv
`default_nettype none
// ============================================================================
//  Module      : memory1_if
//  Description : Block-access bus between the data cache (master) and the
//                main-memory model memory1 (slave). Every cycle is an access.
//  Revision    : 1.0  initial release
// ============================================================================
interface memory1_if;
    logic           read_write;   // 0 = block read, 1 = block write
    logic [9:0]     address;      // byte address, block = address[9:4]
    logic [127:0]   write_data;   // word 0 in [31:0] ... word 3 in [127:96]
    logic [127:0]   read_data;    // registered block, same word ordering

    modport master (
        output read_write,
        output address,
        output write_data,
        input  read_data
    );

    modport slave (
        input  read_write,
        input  address,
        input  write_data,
        output read_data
    );
endinterface
`default_nettype wire

// File: rtl/memory1.sv
`default_nettype none
// ============================================================================
//  Module      : memory1
//  Description : 1 KiB block-addressed main memory (64 blocks x 4 x 32-bit).
//                One full 128-bit block is read or written per cycle; reads
//                have one cycle of registered latency, writes are
//                write-first (the written block appears on read_data).
//  Option      : MEMORY1_INIT_PATTERN_EN - when defined, reset loads each
//                word with its word index (byte address >> 2); otherwise
//                reset clears storage to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module memory1 (
    input  wire logic   clk,
    input  wire logic   rst,
    memory1_if.slave    bus
);
    localparam int c_BLOCKS = 64;
    localparam int c_WORDS  = 4;

    logic [31:0]    r_mem [c_BLOCKS][c_WORDS];
    logic [127:0]   r_read_data;
    logic [5:0]     w_block;
    logic [127:0]   w_block_data;

    // The low four address bits select a byte inside the block and are unused.
    assign w_block = bus.address[9:4];

    // Gather the addressed block into bus word order.
    always_comb begin
        w_block_data = '0;
        for (int w = 0; w < c_WORDS; w++) begin
            w_block_data[w*32 +: 32] = r_mem[w_block][w];
        end
    end

    // Storage update: reset (re)initialises every word, a write replaces the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < c_BLOCKS; b++) begin
                for (int w = 0; w < c_WORDS; w++) begin
`ifdef MEMORY1_INIT_PATTERN_EN
                    r_mem[b][w] <= 32'(b * c_WORDS + w);
`else
                    r_mem[b][w] <= 32'h0;
`endif
                end
            end
        end else if (bus.read_write) begin
            for (int w = 0; w < c_WORDS; w++) begin
                r_mem[w_block][w] <= bus.write_data[w*32 +: 32];
            end
        end
    end

    // Registered read port; a write forwards the new block (write-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_read_data <= 128'h0;
        end else if (bus.read_write) begin
            r_read_data <= bus.write_data;
        end else begin
            r_read_data <= w_block_data;
        end
    end

    assign bus.read_data = r_read_data;

endmodule
`default_nettype wire

// File: tb/tb_memory1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory1
//  Description : Self-checking bench for memory1 with a block-array model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory1;
    logic clk;
    logic rst;
    memory1_if bus ();

    memory1 u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] model [64];

    // Reset contents of one block as described by the memory's initialisation rule.
    function automatic logic [127:0] init_block(input int b);
        logic [127:0] blk;
        blk = '0;
        for (int w = 0; w < 4; w++) begin
`ifdef MEMORY1_INIT_PATTERN_EN
            blk[w*32 +: 32] = 32'(b * 4 + w);
`else
            blk[w*32 +: 32] = 32'h0;
`endif
        end
        return blk;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 64; b++) model[b] = init_block(b);
    endtask

    // Model one non-reset access and return what read_data must show afterwards.
    task automatic model_access(input logic rw, input logic [9:0] a,
                                input logic [127:0] wd, output logic [127:0] exp);
        int b;
        b = int'(a) / 16;
        if (rw) begin
            model[b] = wd;
            exp = wd;
        end else begin
            exp = model[b];
        end
    endtask

    // Apply one cycle of inputs and return 1 ns after the sampling edge.
    task automatic drive(input logic r, input logic rw, input logic [9:0] a,
                         input logic [127:0] wd);
        @(negedge clk);
        rst            = r;
        bus.read_write = rw;
        bus.address    = a;
        bus.write_data = wd;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        logic [127:0] exp;
        logic [127:0] lit;
        drive(1'b1, 1'b0, 10'h000, 128'h0);
        model_reset();
        n_checks++;
        if (bus.read_data !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_value: got %h want %h", bus.read_data, 128'h0);
        end
        drive(1'b0, 1'b0, 10'h030, 128'h0);
        model_access(1'b0, 10'h030, 128'h0, exp);
`ifdef MEMORY1_INIT_PATTERN_EN
        lit = {32'h0F, 32'h0E, 32'h0D, 32'h0C};
`else
        lit = 128'h0;
`endif
        n_checks++;
        if (bus.read_data !== lit || bus.read_data !== exp) begin
            n_fail++;
            $display("FAIL reset_read_030: got %h want %h", bus.read_data, lit);
        end
    endtask

    task automatic test_write_read();
        logic [127:0] wd;
        logic [127:0] exp;
        wd = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
        drive(1'b0, 1'b1, 10'h3F4, wd);
        model_access(1'b1, 10'h3F4, wd, exp);
        n_checks++;
        if (bus.read_data !== wd) begin
            n_fail++;
            $display("FAIL write_first_3F4: got %h want %h", bus.read_data, wd);
        end
        drive(1'b0, 1'b0, 10'h3F0, 128'h0);
        model_access(1'b0, 10'h3F0, 128'h0, exp);
        n_checks++;
        if (bus.read_data !== wd) begin
            n_fail++;
            $display("FAIL read_back_3F0: got %h want %h", bus.read_data, wd);
        end
    endtask

    task automatic test_low_bits();
        logic [127:0] wd;
        logic [127:0] exp;
        wd = rand128();
        drive(1'b0, 1'b1, 10'h05C, wd);
        model_access(1'b1, 10'h05C, wd, exp);
        drive(1'b0, 1'b0, 10'h050, 128'h0);
        n_checks++;
        if (bus.read_data !== wd) begin
            n_fail++;
            $display("FAIL low_bits_050: got %h want %h", bus.read_data, wd);
        end
        drive(1'b0, 1'b0, 10'h05F, 128'h0);
        n_checks++;
        if (bus.read_data !== wd) begin
            n_fail++;
            $display("FAIL low_bits_05F: got %h want %h", bus.read_data, wd);
        end
        drive(1'b0, 1'b0, 10'h060, 128'h0);
        model_access(1'b0, 10'h060, 128'h0, exp);
        n_checks++;
        if (bus.read_data !== exp) begin
            n_fail++;
            $display("FAIL neighbour_060: got %h want %h", bus.read_data, exp);
        end
    endtask

    task automatic test_reset_over_write();
        logic [127:0] exp;
        drive(1'b1, 1'b1, 10'h020, rand128());
        model_reset();
        n_checks++;
        if (bus.read_data !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_write_rd: got %h want %h", bus.read_data, 128'h0);
        end
        drive(1'b0, 1'b0, 10'h024, 128'h0);
        exp = init_block(2);
        n_checks++;
        if (bus.read_data !== exp) begin
            n_fail++;
            $display("FAIL reset_write_blk2: got %h want %h", bus.read_data, exp);
        end
    endtask

    task automatic test_all_blocks();
        logic [127:0] exp;
        drive(1'b1, 1'b0, 10'h000, 128'h0);
        model_reset();
        for (int b = 0; b < 64; b++) begin
            drive(1'b0, 1'b0, 10'(b * 16 + int'($urandom_range(0, 15))), 128'h0);
            exp = init_block(b);
            n_checks++;
            if (bus.read_data !== exp) begin
                n_fail++;
                $display("FAIL all_blocks[%0d]: got %h want %h", b, bus.read_data, exp);
            end
        end
    endtask

    task automatic test_write_lost();
        logic [127:0] wd;
        logic [127:0] exp;
        wd = rand128();
        drive(1'b0, 1'b1, 10'h008, wd);
        model_access(1'b1, 10'h008, wd, exp);
        drive(1'b1, 1'b0, 10'h000, 128'h0);
        model_reset();
        n_checks++;
        if (bus.read_data !== 128'h0) begin
            n_fail++;
            $display("FAIL write_lost_rst: got %h want %h", bus.read_data, 128'h0);
        end
        drive(1'b0, 1'b0, 10'h000, 128'h0);
        exp = init_block(0);
        n_checks++;
        if (bus.read_data !== exp) begin
            n_fail++;
            $display("FAIL write_lost_blk0: got %h want %h", bus.read_data, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] wd;
        logic [127:0] exp;
        wd = rand128();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 10'h1A7, wd);
            model_access(1'b1, 10'h1A7, wd, exp);
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 10'h1A0, 128'h0);
            model_access(1'b0, 10'h1A0, 128'h0, exp);
            n_checks++;
            if (bus.read_data !== exp || bus.read_data !== wd) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h want %h", k, bus.read_data, wd);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] exp;
        logic [127:0] wd;
        logic [9:0]   a;
        logic         rw;
        logic         r;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            rw = $urandom_range(0, 1) == 1;
            a  = 10'($urandom);
            wd = rand128();
            drive(r, rw, a, wd);
            if (r) begin
                model_reset();
                exp = 128'h0;
            end else begin
                model_access(rw, a, wd, exp);
            end
            n_checks++;
            if (bus.read_data !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] rst=%0d rw=%0d a=%h: got %h want %h",
                         i, r, rw, a, bus.read_data, exp);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.read_write = 1'b0;
        bus.address    = 10'h0;
        bus.write_data = 128'h0;
        model_reset();
        test_reset();
        test_write_read();
        test_low_bits();
        test_reset_over_write();
        test_all_blocks();
        test_write_lost();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion want completion");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
